// File: rtl/data_mem_resp.sv
// Word-addressed data RAM with byte-lane writes and a registered, write-first read port.
// Optional MMIO window (DMEM_MMIO_EN): 64-bit cycle counter with a latched upper half, and a console byte FIFO.
module data_mem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  dwea,
  output logic [31:0] rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);
  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_mmio;
  logic                  ram_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           rdata_q, rdata_d;

  assign idx   = addr[DEPTH_LOG2+1:2];
  assign rdata = rdata_q;

`ifdef DMEM_MMIO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [63:0]   cnt_q, cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          sel_lo, sel_hi, sel_data, sel_stat;
  logic          empty, full, pop, push_req, push, ovf_clr;
  logic [31:0]   mmio_rdata;
  logic          unused_bits;

  assign is_mmio  = (addr[31:16] == 16'hFFFF);
  assign sel_lo   = (addr == 32'hFFFF_0000);
  assign sel_hi   = (addr == 32'hFFFF_0004);
  assign sel_data = (addr == 32'hFFFF_0008);
  assign sel_stat = (addr == 32'hFFFF_000C);
  assign unused_bits = ^addr[31:DEPTH_LOG2+2];

  always_comb begin
    cnt_d    = cnt_q + 64'd1;
    // Reading CNT_LO snapshots the upper half so a LO-then-HI pair is coherent.
    shadow_d = sel_lo ? cnt_q[63:32] : shadow_q;
    empty    = (count_q == '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = !empty && con_ready;
    push_req = mem_w && sel_data && dwea[0];
    push     = push_req && (!full || pop);
    ovf_clr  = mem_w && sel_stat && dwea[0] && wdata[2];
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (push_req && full && !pop) ovf_d = 1'b1;
    if (ovf_clr)                  ovf_d = 1'b0;
    mmio_rdata = '0;
    if (sel_lo)   mmio_rdata = cnt_q[31:0];
    if (sel_hi)   mmio_rdata = shadow_q;
    if (sel_stat) mmio_rdata = {25'd0, 4'(count_q), ovf_q, full, empty};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: con_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= wdata[7:0];
  end

  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
`else
  logic unused_bits;

  assign is_mmio     = 1'b0;
  assign con_valid   = 1'b0;
  assign con_data    = 8'h00;
  assign unused_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0], con_ready};
`endif

  // The read word is the merged post-write word, giving write-first behaviour.
  always_comb begin
    ram_we    = mem_w && !rst && !is_mmio;
    mem_wdata = mem_q[idx];
    for (int i = 0; i < 4; i++) begin
      if (ram_we && dwea[i]) mem_wdata[8*i +: 8] = wdata[8*i +: 8];
    end
`ifdef DMEM_MMIO_EN
    rdata_d = is_mmio ? mmio_rdata : mem_wdata;
`else
    rdata_d = mem_wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp; the MMIO scenarios build only when DMEM_MMIO_EN is defined.
module tb_data_mem_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_w = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  dwea = '0;
  logic        con_ready = 1'b0;
  logic [31:0] rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  int          errs = 0;
  int          checks = 0;

  data_mem_resp dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .addr(addr), .wdata(wdata), .dwea(dwea),
    .rdata(rdata), .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_w = 1'b0; dwea = '0; addr = '0; wdata = '0; con_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_w = 1'b1; addr = a; wdata = d; dwea = be;
    tick();
    mem_w = 1'b0; dwea = '0; wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_w = 1'b0; addr = a;
    tick();
    d = rdata;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (con_valid !== 1'b0) begin errs++; $display("FAIL reset_con_valid got=%b exp=0", con_valid); end
    checks++; if (con_data !== 8'h0) begin errs++; $display("FAIL reset_con_data got=%h exp=0", con_data); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    wr(32'h100, 32'h1122_3344, 4'hF);
    checks++; if (rdata !== 32'h1122_3344) begin errs++; $display("FAIL full_write got=%h exp=11223344", rdata); end
    wr(32'h100, 32'hAABB_CCDD, 4'b0101);
    checks++; if (rdata !== 32'h11BB_33DD) begin errs++; $display("FAIL partial_write_wf got=%h exp=11bb33dd", rdata); end
    rd(32'h100, d);
    checks++; if (d !== 32'h11BB_33DD) begin errs++; $display("FAIL partial_read got=%h exp=11bb33dd", d); end
    wr(32'h100, 32'hFFFF_FFFF, 4'h0);
    rd(32'h100, d);
    checks++; if (d !== 32'h11BB_33DD) begin errs++; $display("FAIL dwea_zero got=%h exp=11bb33dd", d); end
  endtask

  task automatic test_write_first();
    wr(32'h40, 32'h0000_0000, 4'hF);
    wr(32'h40, 32'hDEAD_BEEF, 4'hF);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL write_first got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(32'h200, 32'hA5A5_0001, 4'hF);
    wr(32'h204, 32'h5A5A_0002, 4'hF);
    addr = 32'h200; tick();
    checks++; if (rdata !== 32'hA5A5_0001) begin errs++; $display("FAIL b2b_0 got=%h exp=a5a50001", rdata); end
    addr = 32'h204; tick();
    checks++; if (rdata !== 32'h5A5A_0002) begin errs++; $display("FAIL b2b_1 got=%h exp=5a5a0002", rdata); end
    addr = 32'h203; tick();
    checks++; if (rdata !== 32'hA5A5_0001) begin errs++; $display("FAIL low_bits_ignored got=%h exp=a5a50001", rdata); end
    wr(32'h200 + (32'h1 << 12), 32'h0BAD_CAFE, 4'hF);
    rd(32'h200, d);
    checks++; if (d !== 32'h0BAD_CAFE) begin errs++; $display("FAIL alias got=%h exp=0badcafe", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(32'h300, 32'h1111_1111, 4'hF);
    rst = 1'b1; mem_w = 1'b1; addr = 32'h300; wdata = 32'h2222_2222; dwea = 4'hF;
    tick();
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    rst = 1'b0; mem_w = 1'b0; dwea = '0;
    rd(32'h300, d);
    checks++; if (d !== 32'h1111_1111) begin errs++; $display("FAIL rst_write_suppressed got=%h exp=11111111", d); end
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_counter();
    do_reset();
    repeat (10) tick();
    addr = 32'hFFFF_0000; tick();
    checks++; if (rdata !== 32'd10) begin errs++; $display("FAIL cnt_lo got=%0d exp=10", rdata); end
    addr = 32'hFFFF_0004; tick();
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL cnt_hi got=%h exp=0", rdata); end
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    addr = 32'hFFFF_0000; tick();
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL cnt_lo_forced got=%h exp=ffffffff", rdata); end
    force dut.cnt_q = 64'h1234_5678_0000_0010;
    addr = 32'hFFFF_0004; tick();
    checks++; if (rdata !== 32'h0) begin errs++; $display("FAIL cnt_hi_shadow got=%h exp=0", rdata); end
    addr = 32'hFFFF_0000; tick();
    checks++; if (rdata !== 32'h10) begin errs++; $display("FAIL cnt_lo_forced2 got=%h exp=10", rdata); end
    release dut.cnt_q;
    addr = 32'hFFFF_0004; tick();
    checks++; if (rdata !== 32'h1234_5678) begin errs++; $display("FAIL cnt_hi_latched got=%h exp=12345678", rdata); end
  endtask

  task automatic test_console();
    logic [7:0] exp_q [4];
    exp_q = '{8'h42, 8'h43, 8'h44, 8'h5A};
    do_reset();
    mem_w = 1'b1; addr = 32'hFFFF_0008; dwea = 4'h1; wdata = 32'h41;
    #1;
    checks++; if (con_valid !== 1'b0) begin errs++; $display("FAIL no_bypass got=%b exp=0", con_valid); end
    tick();
    checks++; if ({con_valid, con_data} !== {1'b1, 8'h41}) begin errs++; $display("FAIL first_push got=%b/%h exp=1/41", con_valid, con_data); end
    for (int i = 2; i <= 5; i++) begin
      wdata = 32'h40 + i; tick();
    end
    mem_w = 1'b0; dwea = '0; addr = 32'hFFFF_000C; tick();
    checks++; if (rdata !== 32'h26) begin errs++; $display("FAIL stat_full_ovf got=%h exp=26", rdata); end
    mem_w = 1'b1; dwea = 4'h1; addr = 32'hFFFF_0008; wdata = 32'h5A; con_ready = 1'b1;
    #1;
    checks++; if (con_data !== 8'h41) begin errs++; $display("FAIL pop_head got=%h exp=41", con_data); end
    tick();
    mem_w = 1'b0; dwea = '0; con_ready = 1'b0; addr = 32'hFFFF_000C; tick();
    checks++; if (rdata !== 32'h26) begin errs++; $display("FAIL stat_push_pop got=%h exp=26", rdata); end
    wr(32'hFFFF_000C, 32'h4, 4'h1);
    addr = 32'hFFFF_000C; tick();
    checks++; if (rdata !== 32'h22) begin errs++; $display("FAIL ovf_clear got=%h exp=22", rdata); end
    con_ready = 1'b1; addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({con_valid, con_data} !== {1'b1, exp_q[i]}) begin errs++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, con_valid, con_data, exp_q[i]); end
      tick();
    end
    checks++; if ({con_valid, con_data} !== 9'h0) begin errs++; $display("FAIL drained got=%b/%h exp=0/00", con_valid, con_data); end
    con_ready = 1'b0; addr = 32'hFFFF_000C; tick();
    checks++; if (rdata !== 32'h01) begin errs++; $display("FAIL stat_empty got=%h exp=01", rdata); end
    wr(32'hFFFF_0008, 32'h77, 4'h1);
    rst = 1'b1; mem_w = 1'b1; dwea = 4'h1; wdata = 32'h88; tick();
    rst = 1'b0; mem_w = 1'b0; dwea = '0; tick();
    checks++; if (con_valid !== 1'b0) begin errs++; $display("FAIL rst_flush got=%b exp=0", con_valid); end
  endtask

  task automatic test_mmio_misc();
    logic [31:0] d;
    wr(32'h8, 32'hCAFE_F00D, 4'hF);
    wr(32'hFFFF_0010, 32'h1234_5678, 4'hF);
    wr(32'hFFFF_0008, 32'h1234_5678, 4'hE);
    checks++; if (con_valid !== 1'b0) begin errs++; $display("FAIL no_push_lane0_off got=%b exp=0", con_valid); end
    rd(32'h8, d);
    checks++; if (d !== 32'hCAFE_F00D) begin errs++; $display("FAIL mmio_no_ram got=%h exp=cafef00d", d); end
    rd(32'hFFFF_0008, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL con_data_read got=%h exp=0", d); end
    rd(32'hFFFF_0010, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL unmapped_read got=%h exp=0", d); end
  endtask
`else
  task automatic test_no_mmio();
    logic [31:0] d;
    con_ready = 1'b1;
    wr(32'h8, 32'h0, 4'hF);
    wr(32'hFFFF_0008, 32'h1234_5678, 4'hF);
    checks++; if (con_valid !== 1'b0) begin errs++; $display("FAIL no_mmio_valid got=%b exp=0", con_valid); end
    rd(32'h8, d);
    checks++; if (d !== 32'h1234_5678) begin errs++; $display("FAIL no_mmio_alias got=%h exp=12345678", d); end
    rd(32'hFFFF_0000, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL no_mmio_word0 got=%h exp=0", d); end
    checks++; if (con_data !== 8'h0) begin errs++; $display("FAIL no_mmio_data got=%h exp=0", con_data); end
    con_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_byte_lanes();
    test_write_first();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_MMIO_EN
    test_counter();
    test_console();
    test_mmio_misc();
`else
    wr(32'h0, 32'h0, 4'hF);
    test_no_mmio();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
